// File: rtl/shift_dp_pkg.sv
// Shared types for the shift datapath: FSM state, decoded command and the command decoder.
// Build option SHIFT_DP_ARITH_EN (sign-fill on right shift) is handled in shift_dp_lr.
package shift_dp_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        READY   = 2'd1,
        SHIFTED = 2'd2,
        ERR     = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LEFT  = 2'd1,
        CMD_RIGHT = 2'd2,
        CMD_BAD   = 2'd3
    } cmd_t;

    // left/right are only meaningful while shift_en is high.
    function automatic cmd_t decode_cmd(input logic shift_en, input logic left, input logic right);
        cmd_t c;
        c = CMD_NONE;
        if (shift_en) begin
            case ({left, right})
                2'b10:   c = CMD_LEFT;
                2'b01:   c = CMD_RIGHT;
                2'b11:   c = CMD_BAD;
                default: c = CMD_NONE;
            endcase
        end
        return c;
    endfunction

endpackage

// File: rtl/shift_pos_cnt.sv
// Saturating signed up/down counter tracking net shift distance; cleared on load.
module shift_pos_cnt #(
    parameter int W  = 8,
    parameter int PW = $clog2(W) + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 up,
    input  logic                 dn,
    output logic signed [PW-1:0] pos
);

    localparam logic signed [PW-1:0] POS_MAX = PW'(W);
    localparam logic signed [PW-1:0] POS_MIN = -POS_MAX;
    localparam logic signed [PW-1:0] ONE     = PW'(1);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pos <= '0;
        end else if (clr) begin
            pos <= '0;
        end else if (up && (pos != POS_MAX)) begin
            pos <= pos + ONE;
        end else if (dn && (pos != POS_MIN)) begin
            pos <= pos - ONE;
        end
    end

endmodule

// File: rtl/shift_dp_lr.sv
// Bidirectional one-bit-per-cycle shift register with position tracking and sticky flags.
// Define SHIFT_DP_ARITH_EN for sign-fill on right shifts (ser_in then only feeds left shifts).
module shift_dp_lr
    import shift_dp_pkg::*;
#(
    parameter int W  = 8,
    parameter int PW = $clog2(W) + 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [W-1:0]         load_data,
    input  logic                 shift_en,
    input  logic                 left,
    input  logic                 right,
    input  logic                 ser_in,
    output logic [W-1:0]         data_out,
    output logic signed [PW-1:0] pos,
    output logic                 lost,
    output logic                 cmd_err,
    output logic                 ready,
    output state_t               state
);

    cmd_t cmd;
    logic can_shift;
    logic do_left;
    logic do_right;
    logic right_fill;

    always_comb begin
        cmd       = decode_cmd(shift_en, left, right);
        can_shift = !load && ((state == READY) || (state == SHIFTED));
        do_left   = can_shift && (cmd == CMD_LEFT);
        do_right  = can_shift && (cmd == CMD_RIGHT);
    end

`ifdef SHIFT_DP_ARITH_EN
    assign right_fill = data_out[W-1];
`else
    assign right_fill = ser_in;
`endif

    assign ready = (state != EMPTY);

    // Load beats every command; EMPTY flags any shift attempt, ERR waits for a load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            lost     <= 1'b0;
            cmd_err  <= 1'b0;
            state    <= EMPTY;
        end else if (load) begin
            data_out <= load_data;
            lost     <= 1'b0;
            cmd_err  <= 1'b0;
            state    <= READY;
        end else begin
            case (state)
                EMPTY: begin
                    if (shift_en) begin
                        cmd_err <= 1'b1;
                        state   <= ERR;
                    end
                end
                READY, SHIFTED: begin
                    case (cmd)
                        CMD_LEFT: begin
                            data_out <= {data_out[W-2:0], ser_in};
                            lost     <= lost | data_out[W-1];
                            state    <= SHIFTED;
                        end
                        CMD_RIGHT: begin
                            data_out <= {right_fill, data_out[W-1:1]};
                            lost     <= lost | data_out[0];
                            state    <= SHIFTED;
                        end
                        CMD_BAD: begin
                            cmd_err <= 1'b1;
                            state   <= ERR;
                        end
                        default: ;
                    endcase
                end
                ERR: ;
                default: state <= EMPTY;
            endcase
        end
    end

    shift_pos_cnt #(
        .W  (W),
        .PW (PW)
    ) u_pos_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (load),
        .up    (do_left),
        .dn    (do_right),
        .pos   (pos)
    );

endmodule

// File: tb/tb_shift_dp_lr.sv
// Bench for shift_dp_lr: directed scenarios plus random traffic against an arithmetic model.
module tb_shift_dp_lr;
    import shift_dp_pkg::*;

    localparam int W  = 8;
    localparam int PW = $clog2(W) + 2;

    typedef struct packed {
        logic [W-1:0]         data;
        logic signed [PW-1:0] pos;
        logic                 lost;
        logic                 err;
        logic                 rdy;
        state_t               st;
    } exp_t;

    logic                 clk;
    logic                 rst_n;
    logic                 load;
    logic [W-1:0]         load_data;
    logic                 shift_en;
    logic                 left;
    logic                 right;
    logic                 ser_in;
    logic [W-1:0]         data_out;
    logic signed [PW-1:0] pos;
    logic                 lost;
    logic                 cmd_err;
    logic                 ready;
    state_t               state;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // reference model state
    int     m_data = 0;
    int     m_pos  = 0;
    bit     m_lost = 0;
    bit     m_err  = 0;
    state_t m_st   = EMPTY;

    shift_dp_lr #(.W(W), .PW(PW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .shift_en  (shift_en),
        .left      (left),
        .right     (right),
        .ser_in    (ser_in),
        .data_out  (data_out),
        .pos       (pos),
        .lost      (lost),
        .cmd_err   (cmd_err),
        .ready     (ready),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Next-state of the model from the behavioural rules, using plain integer arithmetic.
    task automatic model(input bit r_n, input bit ld, input int ld_val,
                         input bit en, input bit l, input bit r, input bit s);
        int fill;
        if (!r_n) begin
            m_data = 0; m_pos = 0; m_lost = 0; m_err = 0; m_st = EMPTY;
        end else if (ld) begin
            m_data = ld_val; m_pos = 0; m_lost = 0; m_err = 0; m_st = READY;
        end else if (m_st == EMPTY) begin
            if (en) begin m_err = 1; m_st = ERR; end
        end else if (m_st == ERR) begin
        end else if (en && l && r) begin
            m_err = 1; m_st = ERR;
        end else if (en && l) begin
            if (m_data >= 2 ** (W - 1)) m_lost = 1;
            m_data = (m_data * 2 + s) % (2 ** W);
            m_pos  = (m_pos + 1 > W) ? W : m_pos + 1;
            m_st   = SHIFTED;
        end else if (en && r) begin
            if (m_data % 2 == 1) m_lost = 1;
`ifdef SHIFT_DP_ARITH_EN
            fill = (m_data >= 2 ** (W - 1)) ? 1 : 0;
`else
            fill = s;
`endif
            m_data = m_data / 2 + fill * 2 ** (W - 1);
            m_pos  = (m_pos - 1 < -W) ? -W : m_pos - 1;
            m_st   = SHIFTED;
        end
    endtask

    // Drive one cycle at the current negedge, queue the expected result, return at next negedge.
    task automatic step(input bit r_n, input bit ld, input int ld_val,
                        input bit en, input bit l, input bit r, input bit s);
        exp_t e;
        rst_n = r_n; load = ld; load_data = W'(ld_val);
        shift_en = en; left = l; right = r; ser_in = s;
        model(r_n, ld, ld_val, en, l, r, s);
        e.data = W'(m_data);
        e.pos  = PW'(m_pos);
        e.lost = m_lost;
        e.err  = m_err;
        e.rdy  = (m_st != EMPTY);
        e.st   = m_st;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle();
        step(1, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: every cycle with an outstanding expectation, compare the registered outputs.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() != 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("sb_data",    int'(data_out), int'(e.data));
            chk("sb_pos",     int'(pos),      int'(e.pos));
            chk("sb_lost",    int'(lost),     int'(e.lost));
            chk("sb_cmd_err", int'(cmd_err),  int'(e.err));
            chk("sb_ready",   int'(ready),    int'(e.rdy));
            chk("sb_state",   int'(state),    int'(e.st));
        end
    end

    initial begin
        rst_n = 1'b0; load = 1'b0; load_data = '0;
        shift_en = 1'b0; left = 1'b0; right = 1'b0; ser_in = 1'b0;
        @(negedge clk);

        // reset with load asserted
        step(0, 1, 'hFF, 0, 0, 0, 0);
        chk("rst_data", int'(data_out), 0);
        chk("rst_pos", int'(pos), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_flags", int'({lost, cmd_err}), 0);

        // three left shifts of A5
        step(1, 1, 'hA5, 0, 0, 0, 0);
        repeat (3) step(1, 0, 0, 1, 1, 0, 0);
        chk("left3_data", int'(data_out), 'h28);
        chk("left3_pos", int'(pos), 3);
        chk("left3_lost", int'(lost), 1);

        // right shifts
        step(1, 1, 'h81, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 1);
        chk("right_data", int'(data_out), 'hC0);
        chk("right_pos", int'(pos), -1);
        chk("right_lost", int'(lost), 1);
        step(1, 1, 'h01, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0, 1, 0);
        chk("right01_data", int'(data_out), 'h00);

        // illegal left+right, then ignored shift, then recovery by load
        step(1, 1, 'h3C, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 1, 0);
        chk("bad_data", int'(data_out), 'h3C);
        chk("bad_err", int'(cmd_err), 1);
        step(1, 0, 0, 1, 1, 0, 1);
        chk("err_ignore_data", int'(data_out), 'h3C);
        step(1, 1, 'h11, 0, 0, 0, 0);
        chk("recover_err", int'(cmd_err), 0);
        chk("recover_ready", int'(ready), 1);
        chk("recover_state", int'(state), int'(READY));

        // shift while EMPTY, then load+left same cycle
        step(0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 1, 1, 0, 1);
        chk("empty_err", int'(cmd_err), 1);
        chk("empty_data", int'(data_out), 0);
        step(1, 1, 'h0F, 1, 1, 0, 1);
        chk("ldsh_data", int'(data_out), 'h0F);
        chk("ldsh_pos", int'(pos), 0);
        chk("ldsh_err", int'(cmd_err), 0);

        // saturation at +W
        step(1, 1, 'h01, 0, 0, 0, 0);
        repeat (10) step(1, 0, 0, 1, 1, 0, 0);
        chk("sat_pos", int'(pos), 8);
        chk("sat_data", int'(data_out), 0);
        chk("sat_lost", int'(lost), 1);
        step(1, 0, 0, 0, 1, 0, 1);
        step(1, 0, 0, 1, 0, 0, 1);
        chk("noop_pos", int'(pos), 8);

        // saturation at -W
        step(1, 1, 'hF0, 0, 0, 0, 0);
        repeat (11) step(1, 0, 0, 1, 0, 1, 0);
        chk("satneg_pos", int'(pos), -8);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2)
                step(0, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            else if (sel < 14)
                step(1, 1, $urandom_range(0, 255), $urandom_range(0, 1),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
            else if (sel < 20)
                idle();
            else
                step(1, 0, $urandom_range(0, 255), ($urandom_range(0, 9) != 0),
                     $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1));
        end
        idle();

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
